aes_cbc_axis_framer: RTL
========================

Name: aes_cbc_axis_framer

Overview:
- Transmit-side companion of the iterative AES-256-CBC core; produces exactly the input stream that core consumes.
- Accepts one message command (256-bit key, 128-bit IV, direction) and a byte-wide payload stream.
- Emits one AXIS message on the master port: key word 0, key word 1, IV, then 128-bit text blocks, with tuser = direction on every beat and tlast on the final beat.
- Applies PKCS#7 padding on encrypt; zero-fills a partial final block on decrypt and flags an error.

Parameters:
- M_AXIS_WIDTH, 8, master data width in bits; must divide 128; allowed values 8, 16, 32, 64, 128.
- BLOCK_SIZE, 128, AES block width in bits; fixed.

Ports:
- Clk  in  1  clock
- Rst  in  1  reset, synchronous, active-high
- Cmd_valid  in  1  command valid
- Cmd_ready  out  1  command accepted when Cmd_valid & Cmd_ready
- Cmd_key  in  256  AES-256 key
- Cmd_iv  in  128  CBC IV
- Cmd_enc  in  1  1 = encrypt, 0 = decrypt
- S_tdata  in  8  payload byte
- S_tvalid  in  1  payload valid
- S_tready  out  1  payload ready
- S_tlast  in  1  last payload byte of the message
- M_tdata  out  M_AXIS_WIDTH  stream data
- M_tvalid  out  1  stream valid
- M_tready  in  1  stream ready
- M_tlast  out  1  final beat of the message
- M_tuser  out  1  direction (registered Cmd_enc)
- M_tkeep  out  M_AXIS_WIDTH/8  always all ones when M_tvalid
- Err_partial  out  1  one-cycle pulse: decrypt message not a multiple of 16 bytes

Behaviour:
- Reset values: Cmd_ready=0, S_tready=0, M_tvalid=0, M_tdata=0, M_tlast=0, M_tuser=0, M_tkeep=0, Err_partial=0. All counters and the block buffer clear. State goes to ST_IDLE.
- States: ST_IDLE, ST_KEY_0, ST_KEY_1, ST_IV, ST_FILL, ST_PAD, ST_SEND.
- ST_IDLE:
  - Cmd_ready=1.
  - On handshake, register key, IV and enc into local registers, then go to ST_KEY_0.
  - Cmd_ready=0 in every other state.
- Beat order within any 128-bit word is LSB-first: beat i carries word[i*M_AXIS_WIDTH +: M_AXIS_WIDTH]. out_cnt counts 0 .. 128/M_AXIS_WIDTH-1; a beat completes on M_tvalid & M_tready.
- Word sources:
  - ST_KEY_0 sends Cmd_key[127:0].
  - ST_KEY_1 sends Cmd_key[255:128].
  - ST_IV sends Cmd_iv.
  - Each state advances to the next after its last beat completes; ST_IV goes to ST_FILL.
- M_tvalid is 1 in the KEY/IV/SEND states. M_tdata is held stable while M_tvalid & ~M_tready. M_tuser equals the registered enc on all beats of the message.
- ST_FILL:
  - S_tready=1; one byte per cycle goes into buffer byte byte_cnt (bits [byte_cnt*8 +: 8]); byte_cnt is 0..15.
  - Byte 15 accepted with S_tlast=0: go to ST_SEND, final=0.
  - Byte 15 accepted with S_tlast=1: go to ST_SEND. If enc=1, final=0 and pad_full=1; if enc=0, final=1.
  - Byte k<15 accepted with S_tlast=1: go to ST_PAD.
- ST_PAD:
  - S_tready=0.
  - enc=1: fill bytes k+1..15 with value 15-k (PKCS#7); the fill may take one cycle or one cycle per byte.
  - enc=0: fill with 0x00 and pulse Err_partial for exactly one cycle.
  - Set final=1, then go to ST_SEND.
- ST_SEND:
  - S_tready=0; emit the buffer.
  - M_tlast=1 only on the last beat of a block with final=1.
  - After the last beat:
    - final=1: go to ST_IDLE.
    - pad_full=1: load the buffer with 16 × 0x10, set final=1, clear pad_full, stay in ST_SEND.
    - otherwise: clear byte_cnt and go to ST_FILL.
- Payload arriving outside ST_FILL is backpressured (S_tready=0); no byte is ever dropped or duplicated.
- Throughput: no bubble between consecutive words when M_tready is held high. A new block's fill starts the cycle after the previous block's last beat.
- Rst mid-message aborts immediately to reset values. Partial output is not completed, and no tlast is emitted.

Test Plan:
- Rst; command key=00..1f (byte i = i), iv=0xA5 repeated, enc=1; payload 16 bytes 0x00..0x0f with tlast on byte 15 -> 48 header beats in order key[127:0], key[255:128], iv, then block 00..0f, then block 16 × 0x10 with M_tlast on the final beat only; M_tuser=1 on all 80 beats.
- enc=1, 5-byte payload 11 22 33 44 55 -> single text block 11 22 33 44 55 followed by eleven 0x0B, tlast on its byte 15; Err_partial stays 0.
- enc=0, 20-byte payload -> block 1 = bytes 0..15; block 2 = bytes 16..19 then twelve 0x00; Err_partial pulses once; tlast on the last beat of block 2.
- M_AXIS_WIDTH=32, random M_tready (50%) and random S_tvalid, 3 messages back-to-back -> output matches the reference model beat for beat; M_tdata stable under stall; Cmd_ready=1 only in ST_IDLE.
- Rst asserted during the second text block -> next cycle all outputs take reset values; a following full message frames correctly from ST_KEY_0.
- enc=0, 32-byte payload -> exactly 2 text blocks, no pad block, Err_partial=0, M_tuser=0 on all beats.

Source files
------------

// File: rtl/aes_cbc_axis_framer.sv
// ----------------------------------------------------------------------------
// aes_cbc_axis_framer
//
// Transmit-side framer for the iterative AES-256-CBC core. It takes one
// message command (key, IV, direction) plus a byte-wide payload stream and
// emits a single AXIS message: key[127:0], key[255:128], IV, then 128-bit
// text blocks. Encrypt messages get PKCS#7 padding (a full pad block when the
// payload is a multiple of 16 bytes). Decrypt messages that end mid-block
// are zero-filled and flagged on Err_partial.
//
// Ports
//   Clk, Rst        clock, synchronous active-high reset
//   Cmd_*           message command (valid/ready), key, IV, enc (1 = encrypt)
//   S_t*            byte payload stream in (tlast marks the final byte)
//   M_t*            framed stream out; tuser = enc, tkeep all ones when valid
//   Err_partial     one-cycle pulse: decrypt payload not a multiple of 16 bytes
//
// Handshakes: every transfer (Cmd, S, M) happens on a rising edge where
// valid & ready are both high; a valid source holds its data until then.
// Each 128-bit word is sent LSB-first, M_AXIS_WIDTH bits per beat.
// ----------------------------------------------------------------------------
module aes_cbc_axis_framer #(
   parameter int M_AXIS_WIDTH = 8,
   parameter int BLOCK_SIZE   = 128
) (
   input  logic                      Clk,
   input  logic                      Rst,
   input  logic                      Cmd_valid,
   output logic                      Cmd_ready,
   input  logic [255:0]              Cmd_key,
   input  logic [127:0]              Cmd_iv,
   input  logic                      Cmd_enc,
   input  logic [7:0]                S_tdata,
   input  logic                      S_tvalid,
   output logic                      S_tready,
   input  logic                      S_tlast,
   output logic [M_AXIS_WIDTH-1:0]   M_tdata,
   output logic                      M_tvalid,
   input  logic                      M_tready,
   output logic                      M_tlast,
   output logic                      M_tuser,
   output logic [M_AXIS_WIDTH/8-1:0] M_tkeep,
   output logic                      Err_partial
);

   localparam int         BEATS     = BLOCK_SIZE / M_AXIS_WIDTH;
   localparam logic [3:0] LAST_BEAT = 4'(BEATS - 1);

   typedef enum logic [2:0] {
      ST_IDLE, ST_KEY_0, ST_KEY_1, ST_IV, ST_FILL, ST_PAD, ST_SEND
   } state_t;

   state_t                r_state;
   state_t                w_state_next;
   logic [255:0]          r_key;
   logic [127:0]          r_iv;
   logic                  r_enc;
   logic [BLOCK_SIZE-1:0] r_buf;
   logic [3:0]            r_byte_cnt;
   logic [3:0]            r_out_cnt;
   logic                  r_final;
   logic                  r_pad_full;

   logic [127:0]          w_word;
   logic                  w_last_beat;
   logic [7:0]            w_pad_val;

   assign w_last_beat = (r_out_cnt == LAST_BEAT);
   // In ST_PAD r_byte_cnt already points one past the last payload byte,
   // so the PKCS#7 value is simply the number of bytes left in the block.
   assign w_pad_val   = 8'd16 - {4'd0, r_byte_cnt};

   // ---------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------
   always_ff @(posedge Clk) begin
      if (Rst) r_state <= ST_IDLE;
      else     r_state <= w_state_next;
   end

   // ---------------------------------------------------------------------
   // Next state and handshake outputs
   // ---------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      Cmd_ready    = 1'b0;
      S_tready     = 1'b0;
      M_tvalid     = 1'b0;
      w_word       = '0;
      case (r_state)
         ST_IDLE: begin
            // Held low while Rst is asserted so the reset value is visible
            // even if the state register has not yet been cleared.
            Cmd_ready = ~Rst;
            if (Cmd_valid && !Rst) w_state_next = ST_KEY_0;
         end
         ST_KEY_0: begin
            M_tvalid = 1'b1;
            w_word   = r_key[127:0];
            if (M_tready && w_last_beat) w_state_next = ST_KEY_1;
         end
         ST_KEY_1: begin
            M_tvalid = 1'b1;
            w_word   = r_key[255:128];
            if (M_tready && w_last_beat) w_state_next = ST_IV;
         end
         ST_IV: begin
            M_tvalid = 1'b1;
            w_word   = r_iv;
            if (M_tready && w_last_beat) w_state_next = ST_FILL;
         end
         ST_FILL: begin
            S_tready = 1'b1;
            if (S_tvalid) begin
               if (r_byte_cnt == 4'd15) w_state_next = ST_SEND;
               else if (S_tlast)        w_state_next = ST_PAD;
            end
         end
         ST_PAD: begin
            w_state_next = ST_SEND;
         end
         ST_SEND: begin
            M_tvalid = 1'b1;
            w_word   = r_buf;
            if (M_tready && w_last_beat) begin
               if (r_final)         w_state_next = ST_IDLE;
               else if (r_pad_full) w_state_next = ST_SEND;
               else                 w_state_next = ST_FILL;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Outputs derive only from registers, so they stay stable under stall.
   assign M_tdata     = M_tvalid ? w_word[int'(r_out_cnt) * M_AXIS_WIDTH +: M_AXIS_WIDTH]
                                 : '0;
   assign M_tlast     = (r_state == ST_SEND) && r_final && w_last_beat;
   assign M_tuser     = M_tvalid & r_enc;
   assign M_tkeep     = {(M_AXIS_WIDTH/8){M_tvalid}};
   // ST_PAD lasts exactly one cycle, giving a single-cycle pulse.
   assign Err_partial = (r_state == ST_PAD) && !r_enc;

   // ---------------------------------------------------------------------
   // Datapath: command capture, block buffer, counters, final/pad flags
   // ---------------------------------------------------------------------
   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_key      <= '0;
         r_iv       <= '0;
         r_enc      <= 1'b0;
         r_buf      <= '0;
         r_byte_cnt <= '0;
         r_out_cnt  <= '0;
         r_final    <= 1'b0;
         r_pad_full <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (Cmd_valid) begin
                  r_key      <= Cmd_key;
                  r_iv       <= Cmd_iv;
                  r_enc      <= Cmd_enc;
                  r_byte_cnt <= '0;
                  r_out_cnt  <= '0;
                  r_final    <= 1'b0;
                  r_pad_full <= 1'b0;
               end
            end
            ST_KEY_0, ST_KEY_1, ST_IV: begin
               if (M_tready) r_out_cnt <= w_last_beat ? 4'd0 : r_out_cnt + 4'd1;
            end
            ST_FILL: begin
               if (S_tvalid) begin
                  r_buf[int'(r_byte_cnt) * 8 +: 8] <= S_tdata;
                  r_byte_cnt                       <= r_byte_cnt + 4'd1;
                  if (r_byte_cnt == 4'd15) begin
                     // A block-aligned encrypt payload still owes a full
                     // pad block after this one.
                     r_final    <= S_tlast & ~r_enc;
                     r_pad_full <= S_tlast & r_enc;
                  end
               end
            end
            ST_PAD: begin
               for (int j = 0; j < 16; j++) begin
                  if (j >= int'(r_byte_cnt))
                     r_buf[j * 8 +: 8] <= r_enc ? w_pad_val : 8'h00;
               end
               r_final <= 1'b1;
            end
            ST_SEND: begin
               if (M_tready) begin
                  if (w_last_beat) begin
                     r_out_cnt <= '0;
                     if (r_final) begin
                        r_final <= 1'b0;
                     end else if (r_pad_full) begin
                        r_buf      <= {16{8'h10}};
                        r_final    <= 1'b1;
                        r_pad_full <= 1'b0;
                     end else begin
                        r_byte_cnt <= '0;
                     end
                  end else begin
                     r_out_cnt <= r_out_cnt + 4'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
